rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter between two writeback requesters (A = ALU,
// B = LSU) sharing one register-file write port. A granted request is staged
// for one cycle on the rf_* outputs; reads in that cycle see the staged write
// through a forwarding path. Writes to x0 are accepted but suppressed.
module rf_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_valid_i,
  input  logic [4:0]       a_addr_i,
  input  logic [31:0]      a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [4:0]       b_addr_i,
  input  logic [31:0]      b_data_i,
  output logic             b_ready_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [31:0]      rf_wdata_o,
  input  logic [4:0]       rd_addr1_i,
  input  logic [4:0]       rd_addr2_i,
  input  logic [31:0]      rf_rdata1_i,
  input  logic [31:0]      rf_rdata2_i,
  output logic [31:0]      rdata1_o,
  output logic [31:0]      rdata2_o,
  output logic [CNT_W-1:0] wr_cnt_o
);

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  logic             prio_r;
  logic             rf_we_r;
  logic [4:0]       rf_waddr_r;
  logic [31:0]      rf_wdata_r;
  logic [CNT_W-1:0] wr_cnt_r;

  logic             a_grant_s;
  logic             b_grant_s;
  logic             xfer_s;
  logic [4:0]       sel_addr_s;
  logic [31:0]      sel_data_s;

  // Read data seen by a consumer: x0 reads as zero, a matching staged write
  // wins over the (not yet updated) register-file contents.
  function automatic logic [31:0] fwd_data(
    input logic [4:0]  rd_addr,
    input logic [31:0] raw_data,
    input logic        we,
    input logic [4:0]  waddr,
    input logic [31:0] wdata
  );
    logic [31:0] res;
    if (rd_addr == 5'd0) begin
      res = 32'd0;
    end else if (we && (rd_addr == waddr)) begin
      res = wdata;
    end else begin
      res = raw_data;
    end
    return res;
  endfunction

  // Grant selection: single requester wins outright, contention resolved by
  // prio; nothing is granted while reset is held.
  always_comb begin
    a_grant_s  = 1'b0;
    b_grant_s  = 1'b0;
    sel_addr_s = a_addr_i;
    sel_data_s = a_data_i;
    if (rst_i) begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end else begin
      case ({a_valid_i, b_valid_i})
        2'b10:   a_grant_s = 1'b1;
        2'b01:   b_grant_s = 1'b1;
        2'b11: begin
          a_grant_s = (prio_r == PRIO_A);
          b_grant_s = (prio_r == PRIO_B);
        end
        default: begin
          a_grant_s = 1'b0;
          b_grant_s = 1'b0;
        end
      endcase
    end
    if (b_grant_s) begin
      sel_addr_s = b_addr_i;
      sel_data_s = b_data_i;
    end else begin
      sel_addr_s = a_addr_i;
      sel_data_s = a_data_i;
    end
  end

  assign xfer_s    = a_grant_s | b_grant_s;
  assign a_ready_o = a_grant_s;
  assign b_ready_o = b_grant_s;

  // Priority pointer: after a transfer, the side that was not served goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_r <= PRIO_A;
    end else if (a_grant_s) begin
      prio_r <= PRIO_B;
    end else if (b_grant_s) begin
      prio_r <= PRIO_A;
    end else begin
      prio_r <= prio_r;
    end
  end

  // One-entry output stage driving the register-file write port for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 32'd0;
    end else if (xfer_s) begin
      rf_we_r    <= (sel_addr_s != 5'd0);
      rf_waddr_r <= sel_addr_s;
      rf_wdata_r <= sel_data_s;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  // Committed-write counter: bumps at the edge that retires a real write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_r <= {CNT_W{1'b0}};
    end else if (rf_we_r) begin
      wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

  // Forwarded read data for both read ports.
  always_comb begin
    rdata1_o = fwd_data(rd_addr1_i, rf_rdata1_i, rf_we_r, rf_waddr_r, rf_wdata_r);
    rdata2_o = fwd_data(rd_addr2_i, rf_rdata2_i, rf_we_r, rf_waddr_r, rf_wdata_r);
  end

  assign rf_we_o    = rf_we_r;
  assign rf_waddr_o = rf_waddr_r;
  assign rf_wdata_o = rf_wdata_r;
  assign wr_cnt_o   = wr_cnt_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (counter narrowed to 4 bits
// so the wrap-around is reachable).
module tb_rf_wb_arbiter;

  localparam int CNT_W = 4;

  logic             clk_i;
  logic             rst_i;
  logic             a_valid_i;
  logic [4:0]       a_addr_i;
  logic [31:0]      a_data_i;
  logic             a_ready_o;
  logic             b_valid_i;
  logic [4:0]       b_addr_i;
  logic [31:0]      b_data_i;
  logic             b_ready_o;
  logic             rf_we_o;
  logic [4:0]       rf_waddr_o;
  logic [31:0]      rf_wdata_o;
  logic [4:0]       rd_addr1_i;
  logic [4:0]       rd_addr2_i;
  logic [31:0]      rf_rdata1_i;
  logic [31:0]      rf_rdata2_i;
  logic [31:0]      rdata1_o;
  logic [31:0]      rdata2_o;
  logic [CNT_W-1:0] wr_cnt_o;

  int n_chk;
  int n_fail;

  rf_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_valid_i   (a_valid_i),
    .a_addr_i    (a_addr_i),
    .a_data_i    (a_data_i),
    .a_ready_o   (a_ready_o),
    .b_valid_i   (b_valid_i),
    .b_addr_i    (b_addr_i),
    .b_data_i    (b_data_i),
    .b_ready_o   (b_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rd_addr1_i  (rd_addr1_i),
    .rd_addr2_i  (rd_addr2_i),
    .rf_rdata1_i (rf_rdata1_i),
    .rf_rdata2_i (rf_rdata2_i),
    .rdata1_o    (rdata1_o),
    .rdata2_o    (rdata2_o),
    .wr_cnt_o    (wr_cnt_o)
  );

  // Free-running clock, period 10.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_i       = 1'b1;
    a_valid_i   = 1'b0;
    a_addr_i    = 5'd0;
    a_data_i    = 32'd0;
    b_valid_i   = 1'b0;
    b_addr_i    = 5'd0;
    b_data_i    = 32'd0;
    rd_addr1_i  = 5'd0;
    rd_addr2_i  = 5'd0;
    rf_rdata1_i = 32'd0;
    rf_rdata2_i = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_cnt", {28'd0, wr_cnt_o}, 32'd0);
    a_valid_i = 1'b1; a_addr_i = 5'd4; a_data_i = 32'h44;
    b_valid_i = 1'b1; b_addr_i = 5'd6; b_data_i = 32'h66;
    #1;
    chk("rst_no_a_grant", {31'd0, a_ready_o}, 32'd0);
    chk("rst_no_b_grant", {31'd0, b_ready_o}, 32'd0);
    tick();
    a_valid_i = 1'b0; b_valid_i = 1'b0; rst_i = 1'b0;
    chk("rst_no_stage", {31'd0, rf_we_o}, 32'd0);

    // Single A write
    a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'hDEADBEEF;
    #1;
    chk("single_a_ready", {31'd0, a_ready_o}, 32'd1);
    chk("single_b_ready", {31'd0, b_ready_o}, 32'd0);
    tick();
    a_valid_i = 1'b0;
    chk("single_we", {31'd0, rf_we_o}, 32'd1);
    chk("single_waddr", {27'd0, rf_waddr_o}, 32'd5);
    chk("single_wdata", rf_wdata_o, 32'hDEADBEEF);
    chk("single_cnt0", {28'd0, wr_cnt_o}, 32'd0);
    tick();
    chk("single_we_drop", {31'd0, rf_we_o}, 32'd0);
    chk("single_waddr_hold", {27'd0, rf_waddr_o}, 32'd5);
    chk("single_cnt1", {28'd0, wr_cnt_o}, 32'd1);

    // Reset so contention starts from prio = A
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst2_cnt", {28'd0, wr_cnt_o}, 32'd0);

    // Contention: grants alternate A,B,A,B with back-to-back writes
    a_valid_i = 1'b1; a_addr_i = 5'd1; a_data_i = 32'h11;
    b_valid_i = 1'b1; b_addr_i = 5'd2; b_data_i = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont_a_ready%0d", i), {31'd0, a_ready_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont_b_ready%0d", i), {31'd0, b_ready_o}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk($sformatf("cont_we%0d", i), {31'd0, rf_we_o}, 32'd1);
      chk($sformatf("cont_waddr%0d", i), {27'd0, rf_waddr_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("cont_wdata%0d", i), rf_wdata_o, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    chk("cont_cnt3", {28'd0, wr_cnt_o}, 32'd3);
    tick();
    chk("cont_cnt4", {28'd0, wr_cnt_o}, 32'd4);
    chk("cont_idle_we", {31'd0, rf_we_o}, 32'd0);

    // x0 write: accepted, not written, not counted
    b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 32'hFFFFFFFF;
    #1;
    chk("x0_b_ready", {31'd0, b_ready_o}, 32'd1);
    chk("x0_a_ready", {31'd0, a_ready_o}, 32'd0);
    tick();
    b_valid_i = 1'b0;
    chk("x0_we", {31'd0, rf_we_o}, 32'd0);
    tick();
    chk("x0_cnt", {28'd0, wr_cnt_o}, 32'd4);

    // Forwarding
    a_valid_i = 1'b1; a_addr_i = 5'd7; a_data_i = 32'h1234;
    #1;
    chk("fwd_a_ready", {31'd0, a_ready_o}, 32'd1);
    tick();
    a_valid_i = 1'b0;
    rd_addr1_i = 5'd7; rf_rdata1_i = 32'h0;
    rd_addr2_i = 5'd0; rf_rdata2_i = 32'hAAAA5555;
    #1;
    chk("fwd_we", {31'd0, rf_we_o}, 32'd1);
    chk("fwd_rdata1", rdata1_o, 32'h1234);
    chk("fwd_rdata2_x0", rdata2_o, 32'd0);
    rd_addr1_i = 5'd8; rf_rdata1_i = 32'hCAFE;
    rd_addr2_i = 5'd7; rf_rdata2_i = 32'h9;
    #1;
    chk("fwd_miss_rdata1", rdata1_o, 32'hCAFE);
    chk("fwd_port2_rdata2", rdata2_o, 32'h1234);
    tick();
    rd_addr1_i = 5'd7; rf_rdata1_i = 32'h5;
    #1;
    chk("fwd_stale_rdata1", rdata1_o, 32'h5);
    chk("fwd_cnt", {28'd0, wr_cnt_o}, 32'd5);
    rd_addr1_i = 5'd0; rd_addr2_i = 5'd0;

    // Reset mid-stream
    a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'h33;
    tick();
    a_valid_i = 1'b0;
    b_valid_i = 1'b1; b_addr_i = 5'd9; b_data_i = 32'h99;
    rst_i = 1'b1;
    #1;
    chk("mid_we", {31'd0, rf_we_o}, 32'd1);
    chk("mid_waddr", {27'd0, rf_waddr_o}, 32'd3);
    chk("mid_b_ready_rst", {31'd0, b_ready_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    chk("mid_we_cleared", {31'd0, rf_we_o}, 32'd0);
    chk("mid_cnt_cleared", {28'd0, wr_cnt_o}, 32'd0);
    #1;
    chk("mid_b_ready_post", {31'd0, b_ready_o}, 32'd1);
    tick();
    b_valid_i = 1'b0;
    chk("mid_b_we", {31'd0, rf_we_o}, 32'd1);
    chk("mid_b_waddr", {27'd0, rf_waddr_o}, 32'd9);
    chk("mid_b_cnt", {28'd0, wr_cnt_o}, 32'd0);
    tick();
    chk("mid_b_cnt1", {28'd0, wr_cnt_o}, 32'd1);

    // Counter wrap with 17 back-to-back writes
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    a_valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a_addr_i = 5'((i % 31) + 1);
      a_data_i = 32'(i);
      tick();
      if (i >= 15) begin
        chk($sformatf("wrap_cnt%0d", i + 1), {28'd0, wr_cnt_o}, (i == 15) ? 32'd15 : 32'd0);
      end
    end
    a_valid_i = 1'b0;
    tick();
    chk("wrap_cnt17", {28'd0, wr_cnt_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
